// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_lsu
// Purpose  : Single-port 32-bit word data memory behind a load/store unit.
//            It holds one transaction at a time and answers each request
//            LAT cycles after the request is accepted. Loads support
//            lw/lh/lhu/lb/lbu and stores support sw/sh/sb, little-endian.
//            After each accepted response, a one-cycle trace pulse reports
//            the address and data of that transaction.
// Ports    : clk, rst (async, active-low)
//            req_val/req_rdy/req_type/req_addr/req_wdata : request channel
//            resp_val/resp_rdy/resp_data/resp_err         : response channel
//            trace_val/trace_addr/trace_data              : retirement trace
// Config   : define DATA_MEM_LSU_MISALIGN_ERR_EN to report misaligned word
//            and halfword accesses through resp_err. When it is undefined,
//            the offending low address bits are treated as zero.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_lsu #(
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        trace_val,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic        tval_q;
  logic [31:0] taddr_q, tdata_q;

  logic [31:0] mem_q [DEPTH];

  logic          acc, resp_fire, err;
  logic [AW-1:0] idx;
  logic [31:0]   word, load_val, wrep;
  logic [15:0]   half;
  logic [7:0]    byt;
  logic [3:0]    be;

  assign acc       = req_val & req_rdy;
  assign resp_fire = (state_q == S_RESP) & resp_rdy;
  // Only the bits below the memory size select a word. Higher bits wrap.
  assign idx       = req_addr[AW+1:2];
  assign word      = mem_q[idx];
  // addr[0] is ignored for halfwords. That is the same as forcing it to zero.
  assign half      = req_addr[1] ? word[31:16] : word[15:0];
  assign byt       = word[8*req_addr[1:0] +: 8];

`ifdef DATA_MEM_LSU_MISALIGN_ERR_EN
  logic is_word, is_half;
  assign is_word = (req_type == 3'd0) | (req_type == 3'd5);
  assign is_half = (req_type == 3'd1) | (req_type == 3'd2) | (req_type == 3'd6);
  assign err     = (is_word & (req_addr[1:0] != 2'b00)) | (is_half & req_addr[0]);
`else
  assign err     = 1'b0;
`endif

  // Load result. Stores return zero.
  always_comb begin
    load_val = 32'h0;
    case (req_type)
      3'd0:    load_val = word;
      3'd1:    load_val = {{16{half[15]}}, half};
      3'd2:    load_val = {16'h0, half};
      3'd3:    load_val = {{24{byt[7]}}, byt};
      3'd4:    load_val = {24'h0, byt};
      default: load_val = 32'h0;
    endcase
  end

  // Store data is copied to every lane. The byte enables pick the lanes
  // that are written.
  always_comb begin
    be   = 4'b0000;
    wrep = req_wdata;
    case (req_type)
      3'd5: be = 4'b1111;
      3'd6: begin
        be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{req_wdata[15:0]}};
      end
      3'd7: begin
        be   = 4'b0001 << req_addr[1:0];
        wrep = {4{req_wdata[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          data_d = err ? 32'h0 : load_val;
          err_d  = err;
          addr_d = req_addr;
          if (LAT == 1) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The counter hits zero on this edge, so the response shows up
        // LAT cycles after the request was accepted.
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_rdy) begin
          state_d = S_IDLE;
          data_d  = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      tval_q  <= 1'b0;
      taddr_q <= 32'h0;
      tdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      tval_q  <= resp_fire;
      taddr_q <= resp_fire ? addr_q : 32'h0;
      tdata_q <= resp_fire ? data_q : 32'h0;
    end
  end

  // Memory is not reset, so committed stores survive a reset.
  always_ff @(posedge clk) begin
    if (acc && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

  // rst gates req_rdy so it stays low for the whole reset, even between edges.
  assign req_rdy    = rst & (state_q == S_IDLE);
  assign resp_val   = (state_q == S_RESP);
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign trace_val  = tval_q;
  assign trace_addr = taddr_q;
  assign trace_data = tdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_lsu
// Purpose  : Self-checking bench for data_mem_lsu. It uses a table of load
//            and store vectors with a scoreboard queue of expected responses,
//            plus hand-written sequences for reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_lsu;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_val = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_rdy, resp_val, resp_err, trace_val;
  logic [31:0] resp_data, trace_addr, trace_data;

  data_mem_lsu #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .trace_val  (trace_val),
    .trace_addr (trace_addr),
    .trace_data (trace_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic [31:0] a;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] ed, input logic ee, input int h);
    vec_t v;
    v.t = t; v.a = a; v.wd = wd; v.exp_d = ed; v.exp_e = ee; v.hold = h;
    vecs.push_back(v);
  endtask

  // Start at a negedge. Issue one request, check the latency, optionally
  // stall the response, then accept it and check the trace pulse.
  task automatic run_xact(input vec_t v);
    int          waited;
    exp_t        e;
    logic [31:0] held;
    waited = 0;
    while (!req_rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("req_rdy_before_req", 32'(req_rdy), 32'd1);
    req_val   = 1'b1;
    req_type  = v.t;
    req_addr  = v.a;
    req_wdata = v.wd;
    e.d = v.exp_d; e.e = v.exp_e; e.a = v.a;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_val = 1'b0;
    waited = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (resp_val || waited >= 20) break;
    end
    chk("latency", 32'(waited), 32'(LAT));
    if (!resp_val) begin
      void'(sb_q.pop_front());
      return;
    end
    held = resp_data;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("hold_ctl", 32'({resp_val, req_rdy, trace_val}), 32'b100);
      chk("hold_data", resp_data, held);
    end
    resp_rdy = 1'b1;
    #1;
    chk("rdy_in_fire", 32'(req_rdy), 32'd0);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk("resp_data", resp_data, e.d);
    chk("resp_err", 32'(resp_err), 32'(e.e));
    @(negedge clk);
    resp_rdy = 1'b0;
    chk("trace_val", 32'({trace_val, resp_val}), 32'b10);
    chk("trace_addr", trace_addr, e.a);
    chk("trace_data", trace_data, e.d);
    chk("idle_rdy", 32'(req_rdy), 32'd1);
    @(negedge clk);
    chk("trace_clear_val", 32'(trace_val), 32'd0);
    chk("trace_clear_bus", trace_addr | trace_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_resp", 32'({resp_val, resp_err, trace_val}), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_trace_bus", trace_addr | trace_data, 32'h0);
    rst = 1'b1;
    #1;
    chk("rdy_after_rst", 32'(req_rdy), 32'd1);
    @(negedge clk);

    // Vector table. Types: 0 lw,1 lh,2 lhu,3 lb,4 lbu,5 sw,6 sh,7 sb
    add(3'd5, 32'h100, 32'hdeadbeef, 32'h0,        1'b0, 0);
    add(3'd0, 32'h100, 32'h0,        32'hdeadbeef, 1'b0, 5);
    add(3'd5, 32'h100, 32'h80ff0011, 32'h0,        1'b0, 0);
    add(3'd3, 32'h103, 32'h0,        32'hffffff80, 1'b0, 0);
    add(3'd4, 32'h103, 32'h0,        32'h00000080, 1'b0, 0);
    add(3'd1, 32'h102, 32'h0,        32'hffff80ff, 1'b0, 0);
    add(3'd2, 32'h100, 32'h0,        32'h00000011, 1'b0, 0);
    add(3'd5, 32'h200, 32'h11223344, 32'h0,        1'b0, 0);
    add(3'd7, 32'h201, 32'haaaaaa55, 32'h0,        1'b0, 0);
    add(3'd0, 32'h200, 32'h0,        32'h11225544, 1'b0, 0);
    add(3'd6, 32'h202, 32'h1234abcd, 32'h0,        1'b0, 0);
    add(3'd0, 32'h200, 32'h0,        32'habcd5544, 1'b0, 0);
`ifdef DATA_MEM_LSU_MISALIGN_ERR_EN
    add(3'd0, 32'h102, 32'h0,        32'h0,        1'b1, 0);
    add(3'd1, 32'h101, 32'h0,        32'h0,        1'b1, 0);
`else
    add(3'd0, 32'h102, 32'h0,        32'h80ff0011, 1'b0, 0);
    add(3'd1, 32'h101, 32'h0,        32'h00000011, 1'b0, 0);
`endif
    // 0x500 wraps onto word 0x100 in a 1 KiB memory.
    add(3'd0, 32'h500, 32'h0,        32'h80ff0011, 1'b0, 0);
    add(3'd4, 32'h202, 32'h0,        32'h000000cd, 1'b0, 0);
    add(3'd5, 32'h100, 32'hdeadbeef, 32'h0,        1'b0, 0);

    foreach (vecs[i]) run_xact(vecs[i]);

    // Reset in the middle of a WAIT: the in-flight load is dropped.
    req_val  = 1'b1;
    req_type = 3'd0;
    req_addr = 32'h100;
    @(posedge clk);
    #1 req_val = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_resp_val", 32'(resp_val), 32'd0);
    chk("abort_req_rdy", 32'(req_rdy), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_no_resp", 32'({resp_val, trace_val}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rerdy_after_rst", 32'(req_rdy), 32'd1);
    @(negedge clk);
    chk("no_ghost_resp", 32'({resp_val, req_rdy}), 32'b01);
    begin
      vec_t v;
      v.t = 3'd0; v.a = 32'h100; v.wd = 32'h0; v.exp_d = 32'hdeadbeef; v.exp_e = 1'b0; v.hold = 0;
      run_xact(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
